game_speed_ctrl: RTL
====================

# game_speed_ctrl

Speed controller for the game tick divider. Owns the divider's 2-bit `clk_rate` select and accepts faster/slower button requests and score-driven auto-acceleration. Commits rate changes only on a `clk_game` toggle, so the divider never sees a mid-period ratio change. Edge-detects `clk_game` into a single-cycle, pause-gated `game_tick` strobe that the game FSM consumes.

## Interface

- `AUTO_STEP`, default 8: score events per automatic one-step speed-up; legal range 2..255.
- `RESET_RATE`, default 2'b10: rate select after reset; 00 is fastest, 11 is slowest.
- `clk  input  1`: system clock, rising edge; same clock drives the divider.
- `rst_n  input  1`: reset, asynchronous, active-low.
- `clk_game  input  1`: divided game clock from the divider, synchronous to `clk`.
- `btn_faster  input  1`: single-cycle request to decrement the rate select.
- `btn_slower  input  1`: single-cycle request to increment the rate select.
- `pause_tgl  input  1`: single-cycle pause/resume toggle.
- `score_evt  input  1`: single-cycle "point scored" event.
- `auto_en  input  1`: level signal; enables score-driven acceleration.
- `clk_rate  output  2`: registered rate select to the divider.
- `game_tick  output  1`: registered one-cycle strobe per `clk_game` rising edge while running.
- `paused  output  1`: high in PAUSED.
- `rate_pending  output  1`: high while `target_rate` differs from `clk_rate`.

## Operation

- Internal registers:
  - `target_rate[1:0]`
  - `cg_q` (previous `clk_game`)
  - `score_cnt[7:0]`
  - state in {RUN, PAUSED}
- Reset values:
  - `clk_rate` = `target_rate` = RESET_RATE
  - `cg_q` = 0, `score_cnt` = 0
  - state = RUN
  - `game_tick` = 0, `paused` = 0, `rate_pending` = 0
- State transitions:
  - RUN -> PAUSED on `pause_tgl`.
  - PAUSED -> RUN on `pause_tgl`.
  - No other transitions.
- RUN behaviour:
  - Step request (`auto_up`):
    - `auto_up` = `auto_en` & `score_evt` & (`score_cnt` == AUTO_STEP-1).
    - `score_cnt` increments on `score_evt` when `auto_en` is high.
    - It wraps to 0 on `auto_up`.
    - It holds when `auto_en` is low.
  - Net step:
    - up = `btn_faster` | `auto_up`; down = `btn_slower`.
    - up & down in the same cycle: no change.
    - up only: `target_rate` decrements, saturating at 00.
    - down only: `target_rate` increments, saturating at 11.
    - Manual and auto up in the same cycle give one step only.
- PAUSED behaviour:
  - `btn_*` and `score_evt` are ignored.
  - `score_cnt` holds.
- In both states:
  - A pending `target_rate` is still committed; the divider keeps running.
  - Toggle detection is `clk_game` != `cg_q`; `cg_q` <= `clk_game` every cycle.
  - On a toggle, `clk_rate` <= `target_rate`.
  - A request arriving in the same cycle as a toggle is committed at the next toggle, not this one.
- Tick output:
  - `game_tick` <= `clk_game` & ~`cg_q` & (state == RUN).
  - A `pause_tgl` in the same cycle as a rising edge: the tick uses the pre-toggle state.
- `rate_pending` = registered (`target_rate` != `clk_rate`), updated each cycle.

## Timing

- `game_tick` rises exactly one `clk` cycle after `clk_game` rises and is high for one cycle.
- There is one tick per `clk_game` period (rising edges only).
- `clk_rate` changes one cycle after a `clk_game` toggle is first visible, whether the toggle is rising or falling.
- `paused` changes the cycle after `pause_tgl`.
- `rate_pending` asserts two cycles after an accepted request: `target_rate` updates, then the flag registers.
- `rate_pending` deasserts the cycle after the commit.
- Asynchronous reset mid-operation:
  - Clears the pending change; `clk_rate` returns to RESET_RATE immediately, without waiting for a toggle.
  - `cg_q` = 0; if `clk_game` is high at deassertion, one `game_tick` follows. This is accepted.

## Structure

- Shared package `game_pkg`:
  - Rate constants RATE_FAST=2'b00, RATE_SLOW=2'b11.
  - State enum {RUN, PAUSED}.
- One sub-module `game_edge_det`:
  - Holds the `cg_q` register.
  - Outputs `rise` and `toggle` strobes.
- FSM, saturating rate arithmetic and score counter stay in `game_speed_ctrl`.

## Test plan

Divider instantiated with a scaled-down constant; AUTO_STEP=4 for all scenarios.

- **Reset:** hold `rst_n`=0 -> `clk_rate`=10, `paused`=0, `game_tick`=0. Release; after 3 `clk_game` rising edges -> exactly 3 single-cycle `game_tick` pulses.
- **Deferred commit:** `btn_faster` mid-period -> `target_rate`=01 and `rate_pending`=1. `clk_rate` stays 10 until the next `clk_game` toggle, then becomes 01 one cycle later, and `rate_pending`=0 the cycle after that.
- **Saturation and cancel:** 4× `btn_faster` -> `clk_rate` settles at 00. `btn_faster` and `btn_slower` in the same cycle -> no change. 5× `btn_slower` -> settles at 11.
- **Auto acceleration:** `auto_en`=1, 4 `score_evt` -> one step (10 -> 01) and `score_cnt`=0. `auto_en`=0, 4 events -> no change. 4th event coinciding with `btn_faster` -> single step only.
- **Pause:** `pause_tgl` -> `paused`=1 next cycle. No `game_tick` over 2 `clk_game` periods, and `btn_faster` is ignored. A request made before pausing still commits on the next toggle. `pause_tgl` again -> ticks resume.
- **Reset mid-pending:** `btn_slower`, then `rst_n` pulsed low before the next toggle -> `clk_rate`=10 immediately and `rate_pending`=0.

Source files
------------

// File: rtl/game_pkg.sv
// Shared constants, state type and rate helper for the game speed controller.
// Rate 00 is the fastest divider ratio, 11 the slowest.
package game_pkg;

  localparam logic [1:0] RATE_FAST = 2'b00;
  localparam logic [1:0] RATE_SLOW = 2'b11;

  typedef enum logic {
    RUN    = 1'b0,
    PAUSED = 1'b1
  } state_t;

  // One saturating step; opposing requests cancel.
  function automatic logic [1:0] rate_step(
    input logic [1:0] rate,
    input logic       up,
    input logic       dn
  );
    logic [1:0] nxt;
    nxt = rate;
    unique case (1'b1)
      (up & ~dn): begin
        if (rate != RATE_FAST) nxt = rate - 2'd1;
      end
      (dn & ~up): begin
        if (rate != RATE_SLOW) nxt = rate + 2'd1;
      end
      default: nxt = rate;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/game_edge_det.sv
// Edge detector for the divided game clock.
// Keeps the previous sample; rise and toggle are combinational strobes.
module game_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic clk_game,
  output logic rise,
  output logic toggle
);

  logic cg_q;

  // Previous clk_game sample, refreshed every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cg_q <= 1'b0;
    else        cg_q <= clk_game;
  end

  assign rise   = clk_game & ~cg_q;
  assign toggle = clk_game ^ cg_q;

endmodule

// File: rtl/game_speed_ctrl.sv
// Game speed controller: owns the divider rate select, commits changes
// only on clk_game toggles, and emits a pause-gated game_tick strobe.
module game_speed_ctrl
  import game_pkg::*;
#(
  parameter int unsigned AUTO_STEP  = 8,
  parameter logic [1:0]  RESET_RATE = 2'b10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_game,
  input  logic       btn_faster,
  input  logic       btn_slower,
  input  logic       pause_tgl,
  input  logic       score_evt,
  input  logic       auto_en,
  output logic [1:0] clk_rate,
  output logic       game_tick,
  output logic       paused,
  output logic       rate_pending
);

  localparam logic [7:0] CNT_LAST = 8'(AUTO_STEP - 1);

  state_t     state;
  state_t     state_nxt;
  logic       run;
  logic [1:0] target_rate;
  logic [7:0] score_cnt;
  logic       rise;
  logic       toggle;
  logic       cnt_en;
  logic       auto_up;
  logic       step_up;
  logic       step_dn;

  game_edge_det u_edge (
    .clk      (clk),
    .rst_n    (rst_n),
    .clk_game (clk_game),
    .rise     (rise),
    .toggle   (toggle)
  );

  // Run/pause state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  // Next state and request gating; requests only count while running.
  always_comb begin
    state_nxt = state;
    run       = 1'b0;
    cnt_en    = 1'b0;
    auto_up   = 1'b0;
    step_up   = 1'b0;
    step_dn   = 1'b0;
    unique case (state)
      RUN: begin
        run     = 1'b1;
        cnt_en  = auto_en & score_evt;
        auto_up = cnt_en & (score_cnt == CNT_LAST);
        step_up = btn_faster | auto_up;
        step_dn = btn_slower;
        if (pause_tgl) state_nxt = PAUSED;
      end
      PAUSED: begin
        if (pause_tgl) state_nxt = RUN;
      end
    endcase
  end

  // Score events toward the next automatic speed-up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score_cnt <= 8'd0;
    end else if (cnt_en) begin
      if (auto_up) score_cnt <= 8'd0;
      else         score_cnt <= score_cnt + 8'd1;
    end
  end

  // Requested rate; manual and auto up together still give one step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) target_rate <= RESET_RATE;
    else        target_rate <= rate_step(target_rate, step_up, step_dn);
  end

  // Divider select only moves on a game-clock toggle, never mid-period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      clk_rate <= RESET_RATE;
    else if (toggle) clk_rate <= target_rate;
  end

  // Tick strobe uses the state before any same-cycle pause toggle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) game_tick <= 1'b0;
    else        game_tick <= rise & run;
  end

  // Flag an uncommitted rate change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rate_pending <= 1'b0;
    else        rate_pending <= (target_rate != clk_rate);
  end

  assign paused = (state == PAUSED);

endmodule
